up_down_counter_mod: RTL and testbench

//  Parametrised modulo up/down counter, successor to the fixed 8-bit up/down counter.

---
 rtl/up_down_counter_pkg.sv | 22 ++
 rtl/udc_next_value.sv | 94 +++++++++
 rtl/up_down_counter_mod.sv | 110 +++++++++++
 tb/tb_up_down_counter_mod.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// ============================================================================
// Module  : up_down_counter_pkg
// Purpose : Shared encodings for the modulo up/down counter: the sat_mode
//           and up_down control bit meanings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package up_down_counter_pkg;

  // sat_mode encodings
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // up_down encodings
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage : up_down_counter_pkg

`default_nettype wire

// File: rtl/udc_next_value.sv
// ============================================================================
// Module  : udc_next_value
// Purpose : Combinational next-count calculator for one enabled count step,
//           including wrap/saturate handling and overflow/underflow events.
// Ports   : counter   in  WIDTH  current registered count
//           limit     in  WIDTH  inclusive maximum count
//           up_down   in  1      DIR_UP / DIR_DOWN
//           sat_mode  in  1      MODE_WRAP / MODE_SAT
//           next      out WIDTH  count after one enabled step
//           wrap      out 1      step wrapped in either direction
//           ovf_evt   out 1      up-wrap or up-clamp happened
//           unf_evt   out 1      down-wrap or down-clamp happened
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module udc_next_value
  import up_down_counter_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next,
  output logic             wrap,
  output logic             ovf_evt,
  output logic             unf_evt
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] up_wrap_val;
  logic [WIDTH-1:0] dn_wrap_val;

  // Sum is formed one bit wider so overflow past 2**WIDTH-1 is never lost.
  assign sum_x = {1'b0, counter} + STEP_X;

  // Wrapped results always land in 0..limit, so the low WIDTH bits of the
  // modular arithmetic are exact.
  assign up_wrap_val = sum_x[WIDTH-1:0] - limit - WIDTH'(1);
  assign dn_wrap_val = counter - STEP_N + limit + WIDTH'(1);

  always_comb begin
    next    = counter;
    wrap    = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (up_down == DIR_UP) begin
      if (counter > limit) begin
        // Limit was lowered below the count: treat as an overflow.
        ovf_evt = 1'b1;
        if (sat_mode == MODE_SAT) begin
          next = limit;
        end else begin
          next = '0;
          wrap = 1'b1;
        end
      end else if (sum_x <= {1'b0, limit}) begin
        next = sum_x[WIDTH-1:0];
      end else begin
        ovf_evt = 1'b1;
        if (sat_mode == MODE_SAT) begin
          next = limit;
        end else begin
          next = up_wrap_val;
          wrap = 1'b1;
        end
      end
    end else begin
      if (counter > limit) begin
        // Out-of-range count moving down re-enters at the top, silently.
        next = limit;
      end else if ({1'b0, counter} >= STEP_X) begin
        next = counter - STEP_N;
      end else begin
        unf_evt = 1'b1;
        if (sat_mode == MODE_SAT) begin
          next = '0;
        end else begin
          next = dn_wrap_val;
          wrap = 1'b1;
        end
      end
    end
  end

endmodule : udc_next_value

`default_nettype wire

// File: rtl/up_down_counter_mod.sv
// ============================================================================
// Module  : up_down_counter_mod
// Purpose : Parametrised modulo up/down counter with runtime limit, fixed
//           step, wrap/saturate mode, sync clear/load, terminal flags, a wrap
//           pulse and sticky overflow/underflow flags.
// Ports   : clk, reset_n (async active-low)
//           clear, load, load_value, enable, up_down, sat_mode, limit,
//           flag_clr                                   -- control inputs
//           counter, wrap_pulse, sticky_ovf, sticky_unf -- registered outputs
//           at_max, at_zero, cfg_err                   -- combinational outputs
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module up_down_counter_mod
  import up_down_counter_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] counter,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap_pulse,
  output logic             sticky_ovf,
  output logic             sticky_unf,
  output logic             cfg_err
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] nv_next;
  logic             nv_wrap, nv_ovf, nv_unf;
  logic             ovf_set, unf_set;

  udc_next_value #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next (
    .counter  (count_q),
    .limit    (limit),
    .up_down  (up_down),
    .sat_mode (sat_mode),
    .next     (nv_next),
    .wrap     (nv_wrap),
    .ovf_evt  (nv_ovf),
    .unf_evt  (nv_unf)
  );

  assign cfg_err = ({1'b0, limit} < STEP_X);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > limit) ? limit : load_value;
    end else if (enable && !cfg_err) begin
      count_d = nv_next;
      wrap_d  = nv_wrap;
      ovf_set = nv_ovf;
      unf_set = nv_unf;
    end
    // A new event in the same cycle as flag_clr keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~flag_clr);
    unf_d = unf_set | (unf_q & ~flag_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign counter    = count_q;
  assign wrap_pulse = wrap_q;
  assign sticky_ovf = ovf_q;
  assign sticky_unf = unf_q;
  assign at_max     = (count_q == limit);
  assign at_zero    = (count_q == '0);

endmodule : up_down_counter_mod

`default_nettype wire

// File: tb/tb_up_down_counter_mod.sv
// ============================================================================
// Module  : tb_up_down_counter_mod
// Purpose : Self-checking bench; three counters (STEP 1, 3, 4) share inputs
//           and are compared against an arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_up_down_counter_mod;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n, clear, load, enable, up_down, sat_mode, flag_clr;
  logic [W-1:0] load_value, limit;

  logic [W-1:0] cnt    [3];
  logic         at_max [3];
  logic         at_zero[3];
  logic         wrap_p [3];
  logic         s_ovf  [3];
  logic         s_unf  [3];
  logic         cfg_e  [3];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt [3];
  bit m_wrap[3];
  bit m_ovf [3];
  bit m_unf [3];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned ST = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      up_down_counter_mod #(.WIDTH(W), .STEP(ST)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .up_down    (up_down),
        .sat_mode   (sat_mode),
        .limit      (limit),
        .flag_clr   (flag_clr),
        .counter    (cnt[g]),
        .at_max     (at_max[g]),
        .at_zero    (at_zero[g]),
        .wrap_pulse (wrap_p[g]),
        .sticky_ovf (s_ovf[g]),
        .sticky_unf (s_unf[g]),
        .cfg_err    (cfg_e[g])
      );
    end
  endgenerate

  function automatic int step_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end
  endtask

  // One clock edge of the behaviour, evaluated from the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int c, lim, s;
      bit wr, ov, un;
      c = m_cnt[k]; lim = int'(limit); s = step_of(k);
      wr = 0; ov = 0; un = 0;
      if (clear) begin
        c = 0;
      end else if (load) begin
        c = (int'(load_value) < lim) ? int'(load_value) : lim;
      end else if (enable && !(lim < s)) begin
        if (!up_down) begin
          if (c > lim) begin
            ov = 1;
            if (sat_mode) c = lim; else begin c = 0; wr = 1; end
          end else if (c + s <= lim) begin
            c = c + s;
          end else begin
            ov = 1;
            if (sat_mode) c = lim; else begin c = (c + s) % (lim + 1); wr = 1; end
          end
        end else begin
          if (c > lim) begin
            c = lim;
          end else if (c >= s) begin
            c = c - s;
          end else begin
            un = 1;
            if (sat_mode) c = 0; else begin c = c - s + lim + 1; wr = 1; end
          end
        end
      end
      m_cnt[k]  = c;
      m_wrap[k] = wr;
      m_ovf[k]  = ov || (m_ovf[k] && !flag_clr);
      m_unf[k]  = un || (m_unf[k] && !flag_clr);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_cnt%0d", tag, k),  32'(cnt[k]),     32'(m_cnt[k]));
      chk($sformatf("%s_max%0d", tag, k),  32'(at_max[k]),  32'(m_cnt[k] == int'(limit)));
      chk($sformatf("%s_zero%0d", tag, k), 32'(at_zero[k]), 32'(m_cnt[k] == 0));
      chk($sformatf("%s_wrap%0d", tag, k), 32'(wrap_p[k]),  32'(m_wrap[k]));
      chk($sformatf("%s_ovf%0d", tag, k),  32'(s_ovf[k]),   32'(m_ovf[k]));
      chk($sformatf("%s_unf%0d", tag, k),  32'(s_unf[k]),   32'(m_unf[k]));
      chk($sformatf("%s_cfg%0d", tag, k),  32'(cfg_e[k]),   32'(int'(limit) < step_of(k)));
    end
  endtask

  task automatic drive(bit cl, bit ld, int lv, bit en, bit ud, bit sm, int lim, bit fc);
    clear = cl; load = ld; load_value = W'(lv); enable = en;
    up_down = ud; sat_mode = sm; limit = W'(lim); flag_clr = fc;
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int leg;
    bit ud;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 255, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // 1: asynchronous reset mid-count
    drive(0, 1, 37, 0, 0, 0, 255, 0); tick("t1_load");
    chk("t1_at37", 32'(cnt[0]), 32'd37);
    drive(0, 0, 0, 1, 0, 0, 255, 0);  tick("t1_up");
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("t1_async");
    chk("t1_async_zero", 32'(cnt[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick("t1_release");
    chk("t1_release_c0", 32'(cnt[0]), 32'd1);

    // 2: limit 9 wrap-up sequence
    drive(1, 0, 0, 0, 0, 0, 9, 1); tick("t2_clr");
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1, 0, 0, 9, 0);
      tick("t2");
      chk("t2_seq", 32'(cnt[0]), 32'((i + 1) % 10));
      chk("t2_pulse", 32'(wrap_p[0]), 32'(i == 9));
    end
    chk("t2_sticky", 32'(s_ovf[0]), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 9, 1); tick("t2_fclr");
    chk("t2_sticky_clr", 32'(s_ovf[0]), 32'd0);

    // 3: STEP=3, limit 10, down from 1
    drive(0, 1, 1, 0, 1, 0, 10, 0); tick("t3_load");
    drive(0, 0, 0, 1, 1, 0, 10, 0); tick("t3_wrap");
    chk("t3_wrap_cnt", 32'(cnt[1]), 32'd9);
    chk("t3_wrap_unf", 32'(s_unf[1]), 32'd1);
    drive(0, 1, 1, 0, 1, 1, 10, 1); tick("t3_load2");
    drive(0, 0, 0, 1, 1, 1, 10, 0); tick("t3_sat");
    chk("t3_sat_cnt", 32'(cnt[1]), 32'd0);
    chk("t3_sat_unf", 32'(s_unf[1]), 32'd1);

    // 4: priority and load clamp
    drive(1, 1, 5, 1, 0, 0, 100, 0);   tick("t4_clr");
    chk("t4_clr_wins", 32'(cnt[0]), 32'd0);
    drive(0, 1, 5, 1, 0, 0, 100, 0);   tick("t4_load");
    chk("t4_load_wins", 32'(cnt[0]), 32'd5);
    drive(0, 1, 200, 0, 0, 0, 100, 0); tick("t4_clamp");
    chk("t4_load_clamp", 32'(cnt[0]), 32'd100);

    // 5: full-range behaves like the plain 8-bit counter
    drive(0, 1, 255, 0, 0, 0, 255, 1); tick("t5_load");
    drive(0, 0, 0, 1, 0, 0, 255, 0);   tick("t5_up");
    chk("t5_up_wrap", 32'(cnt[0]), 32'd0);
    chk("t5_up_pulse", 32'(wrap_p[0]), 32'd1);
    drive(0, 0, 0, 1, 1, 0, 255, 0);   tick("t5_dn");
    chk("t5_dn_wrap", 32'(cnt[0]), 32'd255);
    leg = 255;
    for (int i = 0; i < 600; i++) begin
      ud = 1'($urandom_range(0, 1));
      drive(0, 0, 0, 1, ud, 0, 255, 0);
      tick("t5_rand");
      leg = ud ? (leg + 255) % 256 : (leg + 1) % 256;
      chk("t5_legacy", 32'(cnt[0]), 32'(leg));
    end

    // 6: limit lowered under the count, illegal config, set-vs-clear race
    drive(0, 1, 50, 0, 0, 0, 255, 1); tick("t6_load");
    drive(0, 0, 0, 1, 0, 0, 20, 0);   tick("t6_up");
    chk("t6_up_cnt", 32'(cnt[0]), 32'd0);
    chk("t6_up_ovf", 32'(s_ovf[0]), 32'd1);
    drive(0, 1, 50, 0, 0, 0, 255, 0); tick("t6_load2");
    drive(0, 0, 0, 1, 1, 0, 20, 0);   tick("t6_dn");
    chk("t6_dn_cnt", 32'(cnt[0]), 32'd20);
    drive(0, 1, 2, 0, 0, 0, 2, 1);    tick("t6_cfg_load");
    chk("t6_cfg_err", 32'(cfg_e[2]), 32'd1);
    drive(0, 0, 0, 1, 0, 0, 2, 0);    tick("t6_cfg_hold");
    chk("t6_cfg_hold", 32'(cnt[2]), 32'd2);
    drive(0, 1, 2, 0, 0, 0, 2, 1);    tick("t6_reload");
    drive(0, 0, 0, 1, 0, 1, 2, 1);    tick("t6_race");
    chk("t6_set_wins", 32'(s_ovf[0]), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 2, 1);    tick("t6_fclr");
    chk("t6_fclr", 32'(s_ovf[0]), 32'd0);

    // randomized mixed traffic
    begin
      int lim;
      lim = 30;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 19) == 0) lim = $urandom_range(0, 255);
        else if ($urandom_range(0, 29) == 0) lim = $urandom_range(0, 5);
        drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 255), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              lim, $urandom_range(0, 9) == 0);
        tick("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_up_down_counter_mod

`default_nettype wire
